// File: rtl/hash_table_pkg.sv
// Shared types and defaults for the IP hash table front end.
package hash_table_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOOKUP = 2'd1,
    ARB_INSERT = 2'd2
  } arb_op_t;

  // Wide enough for up to 16 lookup requesters; unused upper bits stay zero.
  localparam int LK_TAG_ID_W = 4;

  typedef struct packed {
    logic                   valid;
    logic [LK_TAG_ID_W-1:0] id;
  } lk_tag_t;

  localparam int DEF_INS_GAP    = 2;
  localparam int DEF_STARVE_MAX = 8;

endpackage

// File: rtl/data_valid_if.sv
// Valid-qualified data bundle with no backpressure; the master drives, the slave only observes.
interface data_valid_if #(
  parameter int DATA_W = 1
);
  logic              valid;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data);
  modport slave  (input valid, input data);
endinterface

// File: rtl/ip_req_fifo.sv
// Synchronous FIFO without bypass: a push becomes visible at the head one cycle later.
// Pushes are dropped while full and pops are ignored while empty; full stays up on a same-cycle pop.
module ip_req_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_dat,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ip_hash_req_arbiter.sv
// Shares one hash controller between round-robin lookups and gap-spaced queued inserts; issue 1 cycle after grant.
// Lookups are backpressured by lk_rdy_o (combinational grant), inserts by ins_rdy_o (queue not full).
module ip_hash_req_arbiter
  import hash_table_pkg::*;
#(
  parameter int IP_ADDR_W       = 32,
  parameter int NUM_LK          = 2,
  parameter int HASH_PIPE_DEPTH = 2,
  parameter int INS_FIFO_DEPTH  = 4,
  parameter int INS_GAP         = DEF_INS_GAP,
  parameter int STARVE_MAX      = DEF_STARVE_MAX,
  localparam int ID_W           = (NUM_LK > 1) ? $clog2(NUM_LK) : 1,
  localparam int LVL_W          = $clog2(INS_FIFO_DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_LK-1:0]                 lk_val_i,
  input  logic [NUM_LK-1:0][IP_ADDR_W-1:0]  lk_ip_i,
  output logic [NUM_LK-1:0]                 lk_rdy_o,
  input  logic                              ins_val_i,
  input  logic [IP_ADDR_W-1:0]              ins_ip_i,
  output logic                              ins_rdy_o,
  output logic                              hc_insert_val_o,
  output logic                              hc_look_up_val_o,
  output logic [IP_ADDR_W-1:0]              hc_ip_addr_o,
  data_valid_if.slave                       hc_found_if_i,
  output logic                              resp_val_o,
  output logic [ID_W-1:0]                   resp_id_o,
  output logic                              resp_found_o,
  output logic [LVL_W-1:0]                  ins_level_o,
  output logic                              err_o
);

  localparam int GAP_W = (INS_GAP > 0) ? $clog2(INS_GAP + 1) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [IP_ADDR_W-1:0] fifo_dat;
  logic [GAP_W-1:0]     gap_cnt;
  logic [STV_W-1:0]     starve_cnt;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      lk_gnt_id;
  logic [ID_W-1:0]      issue_id;
  logic [ID_W:0]        cand;
  logic                 any_lk;
  logic                 ins_ok;
  arb_op_t              grant_op;
  lk_tag_t              tag_pipe [HASH_PIPE_DEPTH];
  lk_tag_t              tail_tag;
  logic                 tag_id_unused;

  ip_req_fifo #(
    .DATA_W (IP_ADDR_W),
    .DEPTH  (INS_FIFO_DEPTH)
  ) u_ins_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ins_val_i),
    .push_dat (ins_ip_i),
    .pop      (grant_op == ARB_INSERT),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (ins_level_o)
  );

  assign ins_rdy_o = !fifo_full;
  assign any_lk    = |lk_val_i;
  assign ins_ok    = !fifo_empty && (gap_cnt == '0);

  // Descending scan so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_op  = ARB_IDLE;
    lk_gnt_id = '0;
    cand      = '0;
    lk_rdy_o  = '0;
    if (ins_ok && (!any_lk || starve_cnt == STV_W'(STARVE_MAX) || fifo_full)) begin
      grant_op = ARB_INSERT;
    end else if (any_lk) begin
      grant_op = ARB_LOOKUP;
      for (int k = NUM_LK - 1; k >= 0; k--) begin
        cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
        if (cand >= (ID_W + 1)'(NUM_LK)) cand = cand - (ID_W + 1)'(NUM_LK);
        if (lk_val_i[cand[ID_W-1:0]]) lk_gnt_id = cand[ID_W-1:0];
      end
    end
    for (int i = 0; i < NUM_LK; i++) begin
      lk_rdy_o[i] = (grant_op == ARB_LOOKUP) && (lk_gnt_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_insert_val_o  <= 1'b0;
      hc_look_up_val_o <= 1'b0;
      hc_ip_addr_o     <= '0;
      issue_id         <= '0;
      rr_ptr           <= '0;
      gap_cnt          <= '0;
      starve_cnt       <= '0;
      err_o            <= 1'b0;
    end else begin
      hc_insert_val_o  <= (grant_op == ARB_INSERT);
      hc_look_up_val_o <= (grant_op == ARB_LOOKUP);
      if (grant_op == ARB_INSERT) begin
        hc_ip_addr_o <= fifo_dat;
      end else if (grant_op == ARB_LOOKUP) begin
        hc_ip_addr_o <= lk_ip_i[lk_gnt_id];
        issue_id     <= lk_gnt_id;
        rr_ptr       <= (lk_gnt_id == ID_W'(NUM_LK - 1)) ? '0 : lk_gnt_id + 1'b1;
      end

      // The gap keeps back-to-back inserts off the controller's read-modify-write window.
      if (grant_op == ARB_INSERT)  gap_cnt <= GAP_W'(INS_GAP);
      else if (gap_cnt != '0)      gap_cnt <= gap_cnt - 1'b1;

      if (grant_op == ARB_INSERT || fifo_empty)               starve_cnt <= '0;
      else if (ins_ok && starve_cnt != STV_W'(STARVE_MAX))    starve_cnt <= starve_cnt + 1'b1;

      if (hc_found_if_i.valid && !tail_tag.valid) err_o <= 1'b1;
    end
  end

  // Tag pipe mirrors the controller's lookup latency so the tail lines up with found valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HASH_PIPE_DEPTH; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: hc_look_up_val_o, id: LK_TAG_ID_W'(issue_id)};
      for (int i = 1; i < HASH_PIPE_DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tail_tag      = tag_pipe[HASH_PIPE_DEPTH-1];
  assign tag_id_unused = |tail_tag.id;
  assign resp_val_o    = hc_found_if_i.valid;
  assign resp_id_o     = tail_tag.id[ID_W-1:0];
  assign resp_found_o  = hc_found_if_i.data[0];

endmodule

// File: tb/tb_ip_hash_req_arbiter.sv
// Bench for ip_hash_req_arbiter with a behavioural hash controller (found = address bit 0).
module tb_ip_hash_req_arbiter;

  localparam int D = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       lk_val;
  logic [1:0][31:0] lk_ip;
  logic [1:0]       lk_rdy_o;
  logic             ins_val;
  logic [31:0]      ins_ip;
  logic             ins_rdy_o;
  logic             hc_insert_val_o;
  logic             hc_look_up_val_o;
  logic [31:0]      hc_ip_addr_o;
  logic             resp_val_o;
  logic [0:0]       resp_id_o;
  logic             resp_found_o;
  logic [2:0]       ins_level_o;
  logic             err_o;
  logic             inj;

  logic [D-1:0]     mdl_v = '0;
  logic [D-1:0]     mdl_f = '0;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int peak_lvl;
  int t0;

  int          lkid_q[$];
  bit          lkf_q[$];
  logic [31:0] lka_q[$];
  logic [31:0] ins_q[$];
  int          ins_iss_cyc[$];

  data_valid_if #(.DATA_W(1)) found_if ();

  assign found_if.valid   = mdl_v[D-1] | inj;
  assign found_if.data[0] = mdl_f[D-1] | inj;

  ip_hash_req_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .lk_val_i         (lk_val),
    .lk_ip_i          (lk_ip),
    .lk_rdy_o         (lk_rdy_o),
    .ins_val_i        (ins_val),
    .ins_ip_i         (ins_ip),
    .ins_rdy_o        (ins_rdy_o),
    .hc_insert_val_o  (hc_insert_val_o),
    .hc_look_up_val_o (hc_look_up_val_o),
    .hc_ip_addr_o     (hc_ip_addr_o),
    .hc_found_if_i    (found_if),
    .resp_val_o       (resp_val_o),
    .resp_id_o        (resp_id_o),
    .resp_found_o     (resp_found_o),
    .ins_level_o      (ins_level_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: lookup latency D, shares rst with the arbiter.
  always @(posedge clk) begin
    if (rst) begin
      mdl_v <= '0;
      mdl_f <= '0;
    end else begin
      mdl_v <= (mdl_v << 1) | D'(hc_look_up_val_o);
      mdl_f <= (mdl_f << 1) | D'(hc_look_up_val_o & hc_ip_addr_o[0]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted handshakes, pop on controller issue and on response.
  always @(negedge clk) begin
    if (rst) begin
      lkid_q.delete();
      lkf_q.delete();
      lka_q.delete();
      ins_q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (lk_val[i] && lk_rdy_o[i]) begin
          lkid_q.push_back(i);
          lkf_q.push_back(lk_ip[i][0]);
          lka_q.push_back(lk_ip[i]);
        end
      end
      if (ins_val && ins_rdy_o) ins_q.push_back(ins_ip);
      if (hc_insert_val_o && hc_look_up_val_o) chk("hc_both_strobes", 1, 0);
      if (hc_insert_val_o) begin
        ins_iss_cyc.push_back(cyc);
        if (ins_q.size() == 0) chk("ins_unexpected", 1, 0);
        else chk("ins_addr", hc_ip_addr_o, ins_q.pop_front());
      end
      if (hc_look_up_val_o) begin
        if (lka_q.size() == 0) chk("lk_unexpected", 1, 0);
        else chk("lk_addr", hc_ip_addr_o, lka_q.pop_front());
      end
      if (resp_val_o && !inj) begin
        if (lkid_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          chk("resp_id", resp_id_o, lkid_q.pop_front());
          chk("resp_found", resp_found_o, lkf_q.pop_front());
        end
      end
      if (int'(ins_level_o) > peak_lvl) peak_lvl = int'(ins_level_o);
    end
  end

  initial begin
    rst = 1'b1; lk_val = '0; lk_ip = '0; ins_val = 1'b0; ins_ip = '0; inj = 1'b0;
    peak_lvl = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_hc_ins", hc_insert_val_o, 0);
    chk("rst_hc_lk", hc_look_up_val_o, 0);
    chk("rst_hc_addr", hc_ip_addr_o, 0);
    chk("rst_resp", resp_val_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_level", ins_level_o, 0);
    chk("rst_ins_rdy", ins_rdy_o, 1);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single lookup from requester 1.
    lk_val = 2'b10; lk_ip[1] = 32'h0A00_0001;
    @(negedge clk); chk("t1_rdy", lk_rdy_o, 2'b10);
    tick(); lk_val = '0;
    @(negedge clk); chk("t1_hc_lk", hc_look_up_val_o, 1); chk("t1_hc_addr", hc_ip_addr_o, 32'h0A00_0001);
    tick();
    @(negedge clk); chk("t1_resp_early", resp_val_o, 0);
    tick();
    @(negedge clk);
    chk("t1_resp_val", resp_val_o, 1); chk("t1_resp_id", resp_id_o, 1); chk("t1_resp_found", resp_found_o, 1);
    tick();

    // Both requesters continuously: strict alternation from pointer 0.
    for (int k = 0; k < 6; k++) begin
      lk_val = 2'b11; lk_ip[0] = 32'h1000_0000 + k; lk_ip[1] = 32'h2000_0001 + k;
      @(negedge clk);
      chk("t2_grant", lk_rdy_o, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("t2_no_ins", hc_insert_val_o, 0);
      tick();
    end
    lk_val = '0;
    repeat (5) tick();
    @(negedge clk); chk("t2_drained", lkid_q.size(), 0);
    tick();

    // Four back-to-back inserts, no lookups.
    peak_lvl = 0; ins_iss_cyc.delete(); t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      ins_val = 1'b1; ins_ip = 32'hC0A8_0000 + k;
      tick();
    end
    ins_val = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    chk("t3_ins_count", ins_iss_cyc.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t3_ins_cycle", (k < ins_iss_cyc.size()) ? ins_iss_cyc[k] : -1, t0 + 2 + 3 * k);
    chk("t3_peak_level", peak_lvl, 3);
    tick();

    // Starvation: one queued insert against saturating lookups.
    lk_val = 2'b11; ins_val = 1'b1; ins_ip = 32'hC0A8_00F0;
    for (int k = 0; k < 11; k++) begin
      if (k == 1) ins_val = 1'b0;
      lk_ip[0] = 32'h3000_0000 + k; lk_ip[1] = 32'h4000_0000 + 2 * k;
      @(negedge clk);
      chk("t4_lk_granted", |lk_rdy_o, k != 9);
      chk("t4_hc_insert", hc_insert_val_o, k == 10);
      tick();
    end
    lk_val = '0;
    repeat (6) tick();

    // Fill the queue under lookup load; full forces the insert.
    lk_val = 2'b11;
    for (int k = 0; k < 7; k++) begin
      ins_val = (k <= 4); ins_ip = 32'hC0A8_0100 + k;
      lk_ip[0] = 32'h5000_0000 + k; lk_ip[1] = 32'h6000_0001 + k;
      @(negedge clk);
      if (k == 4) begin
        chk("t5_full_rdy", ins_rdy_o, 0); chk("t5_full_level", ins_level_o, 4); chk("t5_full_lk_rdy", lk_rdy_o, 0);
      end
      if (k == 5) begin
        chk("t5_pop_rdy", ins_rdy_o, 1); chk("t5_pop_level", ins_level_o, 3); chk("t5_pop_hc_ins", hc_insert_val_o, 1);
      end
      tick();
    end
    lk_val = '0; ins_val = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("t5_ins_drained", ins_q.size(), 0); chk("t5_lk_drained", lkid_q.size(), 0); chk("t5_level_empty", ins_level_o, 0);
    tick();

    // Found valid with no tag in flight.
    inj = 1'b1;
    @(negedge clk); chk("t6_inj_resp", resp_val_o, 1); chk("t6_err_before", err_o, 0);
    tick(); inj = 1'b0;
    @(negedge clk); chk("t6_err_set", err_o, 1);
    repeat (3) tick();
    @(negedge clk); chk("t6_err_sticky", err_o, 1);
    tick();

    // Reset in the middle of mixed traffic.
    lk_val = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ins_val = 1'b1; ins_ip = 32'hC0A8_0200 + k;
      lk_ip[0] = 32'h7000_0000 + k; lk_ip[1] = 32'h7100_0001 + k;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; lk_val = '0; ins_val = 1'b0;
    @(negedge clk);
    chk("t7_hc_ins", hc_insert_val_o, 0); chk("t7_hc_lk", hc_look_up_val_o, 0);
    chk("t7_hc_addr", hc_ip_addr_o, 0); chk("t7_resp", resp_val_o, 0);
    chk("t7_err", err_o, 0); chk("t7_level", ins_level_o, 0); chk("t7_ins_rdy", ins_rdy_o, 1);
    repeat (8) tick();
    @(negedge clk); chk("t7_quiet_level", ins_level_o, 0); chk("t7_quiet_err", err_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
